// File: rtl/fetch_if.sv
// Fetch-to-memory/decode bus: instruction memory port, redirect input,
// the valid/ready handoff to decode, and status outputs.
interface fetch_if;
    logic [31:0] o_pc;
    logic [31:0] i_instruction;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        i_ready;
    logic        o_done;
    logic [31:0] o_fetch_count;

    modport master (
        output o_pc, o_valid, o_instr, o_instr_pc, o_done, o_fetch_count,
        input  i_instruction, i_redirect, i_redirect_pc, i_ready
    );

    modport slave (
        input  o_pc, o_valid, o_instr, o_instr_pc, o_done, o_fetch_count,
        output i_instruction, i_redirect, i_redirect_pc, i_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: word-indexed PC, one-entry fetch register toward
// decode, redirect with flush, and end-of-program detection.
module fetch_unit #(
    parameter logic [31:0] RESET_PC         = 32'd0,
    parameter logic [31:0] NUM_INSTRUCTIONS = 32'd11
) (
    input  logic    i_clk,
    input  logic    i_rst,
    fetch_if.master bus
);
    typedef enum logic [1:0] {
        ST_RUN,
        ST_END,
        ST_DONE
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc_p0;
    logic        vld_p1;
    logic [31:0] instr_p1;
    logic [31:0] instr_pc_p1;
    logic [31:0] fetch_count;
    logic        xfer;
    logic        load;

    function automatic logic in_range(input logic [31:0] pc);
        return pc < NUM_INSTRUCTIONS;
    endfunction

    assign xfer = vld_p1 && bus.i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= in_range(RESET_PC) ? ST_RUN : ST_END;
        end else begin
            state <= state_n;
        end
    end

    // In RUN the PC is always in range, so pc_p0 + 1 cannot wrap.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        if (bus.i_redirect) begin
            state_n = in_range(bus.i_redirect_pc) ? ST_RUN : ST_END;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!vld_p1 || bus.i_ready) begin
                        load = 1'b1;
                        if (!in_range(pc_p0 + 32'd1)) begin
                            state_n = ST_END;
                        end
                    end
                end
                ST_END: begin
                    if (!vld_p1 || xfer) begin
                        state_n = ST_DONE;
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end
    end

    // ---- stage p0 -> p1: PC update and fetch register load ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_p0       <= RESET_PC;
            vld_p1      <= 1'b0;
            instr_p1    <= 32'd0;
            instr_pc_p1 <= 32'd0;
            fetch_count <= 32'd0;
        end else begin
            if (xfer) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (bus.i_redirect) begin
                pc_p0  <= bus.i_redirect_pc;
                vld_p1 <= 1'b0;
            end else if (load) begin
                instr_p1    <= bus.i_instruction;
                instr_pc_p1 <= pc_p0;
                vld_p1      <= 1'b1;
                pc_p0       <= pc_p0 + 32'd1;
            end else if (xfer) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.o_pc          = pc_p0;
    assign bus.o_valid       = vld_p1;
    assign bus.o_instr       = instr_p1;
    assign bus.o_instr_pc    = instr_pc_p1;
    assign bus.o_done        = (state == ST_DONE);
    assign bus.o_fetch_count = fetch_count;
endmodule
